// File: rtl/neuron_mac.sv
// neuron_mac: sequential multiply-accumulate neuron with a step activation.
// It streams weight/input pairs from two synchronous memories and compares the signed sum against THRESH.
module neuron_mac #(
  parameter int N_INPUTS = 10,
  parameter int W = 16,
  parameter int ACC_W = 40,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [15:0]             rom_addr,
  input  logic signed [W-1:0]     w_data,
  output logic [15:0]             x_addr,
  input  logic signed [W-1:0]     x_data,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    fire
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ACT, DONE} state_t;
  state_t state;
  logic vld;
  logic signed [ACC_W-1:0] acc;
  logic signed [2*W-1:0] prod;
  assign prod = w_data * x_data;
  assign x_addr = rom_addr;
  // vld marks the cycle in which read data for an issued address (1..N_INPUTS) is present
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rom_addr <= '0;
      vld <= 1'b0;
      acc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      acc_out <= '0;
      fire <= 1'b0;
    end else begin
      vld <= (state == ISSUE);
      if (vld) acc <= acc + ACC_W'(prod);
      case (state)
        IDLE:
          if (start) begin
            state <= ISSUE;
            rom_addr <= 16'd1;
            acc <= '0;
            busy <= 1'b1;
          end
        ISSUE:
          if (rom_addr == 16'(N_INPUTS)) begin
            state <= DRAIN;
            rom_addr <= '0;
          end else rom_addr <= rom_addr + 16'd1;
        DRAIN: state <= ACT;
        ACT: begin
          state <= DONE;
          acc_out <= acc;
          fire <= (acc >= THRESH);
          done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: randomized and directed checks of neuron_mac against an arithmetic sum-of-products model.
module tb_neuron_mac;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, start1 = 1'b0;
  logic [15:0] rom_addr, x_addr, rom_addr1, x_addr1;
  logic signed [15:0] w_data, x_data, w1_data, x1_data;
  logic busy, done, fire, busy1, done1, fire1;
  logic signed [39:0] acc_out, acc_out1;
  logic signed [15:0] wmem [0:10];
  logic signed [15:0] xmem [0:10];
  logic signed [15:0] w1, x1;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  // synchronous memories: data follows the address by one cycle; address 0 holds non-zero bait
  always @(posedge clk) begin
    w_data <= wmem[rom_addr];
    x_data <= xmem[x_addr];
    w1_data <= (rom_addr1 == 16'd1) ? w1 : 16'sh1234;
    x1_data <= (x_addr1 == 16'd1) ? x1 : 16'sh0101;
  end

  neuron_mac dut (.clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .w_data(w_data),
    .x_addr(x_addr), .x_data(x_data), .busy(busy), .done(done), .acc_out(acc_out), .fire(fire));
  neuron_mac #(.N_INPUTS(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .rom_addr(rom_addr1),
    .w_data(w1_data), .x_addr(x_addr1), .x_data(x1_data), .busy(busy1), .done(done1),
    .acc_out(acc_out1), .fire(fire1));

  function automatic logic signed [39:0] model();
    longint s = 0;
    for (int k = 1; k <= 10; k++) s += longint'(wmem[k]) * longint'(xmem[k]);
    return 40'(s);
  endfunction

  task automatic set_spec(input logic signed [15:0] xv);
    int ws [10] = '{0, 0, 4, 5, 6, 8, 0, 0, 0, 0};
    wmem[0] = 16'sh0777;
    xmem[0] = 16'sh0333;
    for (int k = 1; k <= 10; k++) begin
      wmem[k] = 16'(ws[k-1]);
      xmem[k] = xv;
    end
  endtask

  // one evaluation: returns done latency and count of address/busy deviations
  task automatic run(output int lat, output int errs);
    errs = 0;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rom_addr !== (k <= 10 ? 16'(k) : 16'd0) || x_addr !== rom_addr || busy !== 1'b1) errs++;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_eval(input string name);
    int lat, errs;
    logic signed [39:0] e;
    e = model();
    run(lat, errs);
    total++; if (lat !== 13) $display("FAIL %s latency: got %0d want 13", name, lat); else passed++;
    total++; if (errs !== 0) $display("FAIL %s addr/busy seq: %0d bad cycles want 0", name, errs); else passed++;
    total++; if (acc_out !== e) $display("FAIL %s acc_out: got %0d want %0d", name, acc_out, e); else passed++;
    total++; if (fire !== (e >= 40'sd0)) $display("FAIL %s fire: got %b want %b", name, fire, e >= 40'sd0); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s after done: done=%b busy=%b want 0 0", name, done, busy); else passed++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++; if (rom_addr !== 16'd0 || x_addr !== 16'd0) $display("FAIL reset addr: got %h/%h want 0", rom_addr, x_addr); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset busy/done: got %b%b want 00", busy, done); else passed++;
    total++; if (acc_out !== 40'sd0 || fire !== 1'b0) $display("FAIL reset result: got %0d/%b want 0/0", acc_out, fire); else passed++;
    total++; if (busy1 !== 1'b0 || acc_out1 !== 40'sd0) $display("FAIL reset dut1: got %b/%0d want 0/0", busy1, acc_out1); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pos();
    set_spec(16'sd1);
    test_eval("pos");
    total++; if (acc_out !== 40'sd23) $display("FAIL pos literal: got %0d want 23", acc_out); else passed++;
  endtask

  task automatic test_neg();
    set_spec(-16'sd1);
    test_eval("neg");
    total++; if (acc_out !== -40'sd23 || fire !== 1'b0) $display("FAIL neg literal: got %0d/%b want -23/0", acc_out, fire); else passed++;
  endtask

  task automatic test_zero();
    set_spec(16'sd9);
    for (int k = 1; k <= 10; k++) wmem[k] = 16'sd0;
    test_eval("zero");
    total++; if (acc_out !== 40'sd0 || fire !== 1'b1) $display("FAIL zero boundary: got %0d/%b want 0/1", acc_out, fire); else passed++;
  endtask

  task automatic test_max();
    for (int k = 1; k <= 10; k++) begin
      wmem[k] = 16'sh8000;
      xmem[k] = 16'sh8000;
    end
    test_eval("max");
    total++; if (acc_out !== 40'sd10737418240) $display("FAIL max literal: got %0d want 10737418240", acc_out); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k <= 10; k++) begin
        wmem[k] = 16'($urandom);
        xmem[k] = 16'($urandom);
      end
      test_eval($sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    set_spec(16'sd1);
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done === 1'b1) q.push_back(n);
    end
    start = 1'b0;
    total++; if (q.size() !== 3) $display("FAIL b2b pulse count: got %0d want 3", q.size()); else passed++;
    if (q.size() == 3) begin
      total++; if (q[0] !== 13 || q[1] !== 27 || q[2] !== 41)
        $display("FAIL b2b done cycles: got %0d,%0d,%0d want 13,27,41", q[0], q[1], q[2]); else passed++;
    end
    total++; if (acc_out !== 40'sd23) $display("FAIL b2b acc_out: got %0d want 23", acc_out); else passed++;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    set_spec(16'sd1);
    @(negedge clk);
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (rom_addr !== 16'd0 || busy !== 1'b0) $display("FAIL midreset state: addr=%0d busy=%b want 0 0", rom_addr, busy); else passed++;
    total++; if (acc_out !== 40'sd0 || fire !== 1'b0) $display("FAIL midreset result: got %0d/%b want 0/0", acc_out, fire); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    total++; if (dn !== 0) $display("FAIL midreset stray activity: %0d cycles want 0", dn); else passed++;
    test_eval("after_reset");
    total++; if (acc_out !== 40'sd23) $display("FAIL after_reset literal: got %0d want 23", acc_out); else passed++;
  endtask

  task automatic test_single();
    for (int i = 0; i < 3; i++) begin
      int lat = -1;
      logic signed [39:0] e;
      w1 = (i == 0) ? 16'sd7 : 16'($urandom);
      x1 = (i == 0) ? -16'sd3 : 16'($urandom);
      e = 40'(longint'(w1) * longint'(x1));
      @(negedge clk);
      start1 = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        start1 = 1'b0;
        if (done1 === 1'b1) begin
          lat = k;
          break;
        end
      end
      total++; if (lat !== 4) $display("FAIL single%0d latency: got %0d want 4", i, lat); else passed++;
      total++; if (acc_out1 !== e || fire1 !== (e >= 40'sd0))
        $display("FAIL single%0d result: got %0d/%b want %0d/%b", i, acc_out1, fire1, e, e >= 40'sd0); else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    set_spec(16'sd1);
    w1 = 16'sd0;
    x1 = 16'sd0;
    test_reset();
    test_pos();
    test_neg();
    test_zero();
    test_max();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_single();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter N_INPUTS, default 10: number of weight/input pairs per evaluation (1..256).
REQ-002 Parameter W, default 16: width of weights and inputs, signed two's complement.
REQ-003 Parameter ACC_W, default 40: accumulator width, signed.
REQ-004 Parameter THRESH, default 0: signed ACC_W-bit firing threshold.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  request one evaluation; sampled only in IDLE.
REQ-008 rom_addr  output  16  weight ROM address; registered.
REQ-009 w_data  input  W  weight ROM read data, valid one cycle after rom_addr.
REQ-010 x_addr  output  16  input-buffer address, always equal to rom_addr.
REQ-011 x_data  input  W  input-buffer read data, valid one cycle after x_addr.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse when the result is valid.
REQ-014 acc_out  output  ACC_W  signed weighted sum, held until the next accepted start.
REQ-015 fire  output  1  step activation result, held with acc_out.

Function
REQ-016 States SHALL be IDLE, ISSUE, DRAIN, ACT, DONE; each state occupies whole cycles.
REQ-017 IDLE: rom_addr=0, busy=0; start=1 clears the accumulator and moves to ISSUE with rom_addr=1.
REQ-018 ISSUE: rom_addr increments by 1 each cycle, 1..N_INPUTS; after N_INPUTS is issued, move to DRAIN and set rom_addr=0.
REQ-019 A one-bit valid pipeline SHALL track issued addresses; when it is set, acc += sign-extended (w_data * x_data), with a 2W-bit signed product.
REQ-020 DRAIN lasts one cycle and accumulates the last product; ACT registers acc_out=acc and fire=(acc >= THRESH), compared signed.
REQ-021 DONE lasts one cycle: done=1, busy=0 on the next cycle, return to IDLE.
REQ-022 done SHALL assert exactly N_INPUTS+3 cycles after the edge that accepts start (default 13).
REQ-023 start in any state other than IDLE SHALL be ignored, including the DONE cycle; there is no queuing.
REQ-024 The accumulator SHALL wrap modulo 2^ACC_W; no saturation (with defaults, overflow is impossible for N_INPUTS<=256).
REQ-025 N_INPUTS=1 SHALL be legal: ISSUE lasts one cycle, and done follows 4 cycles after start.
REQ-026 rom_addr never takes values above N_INPUTS; address 0 is never accumulated.

Reset
REQ-027 With rst_n=0, the block SHALL immediately enter IDLE with rom_addr=0, x_addr=0, busy=0, done=0, acc_out=0, fire=0, the accumulator at 0 and the valid pipeline cleared.
REQ-028 Reset during ISSUE, DRAIN or ACT SHALL abort the evaluation with no done pulse; the first start after rst_n rises is accepted normally.

Verification
REQ-029 Weights 0,0,4,5,6,8,0,0,0,0 at addresses 1..10, all inputs = 1, start pulse -> rom_addr steps 1..10; done at cycle 13; acc_out=23, fire=1.
REQ-030 Same weights, all inputs = -1 (16'hFFFF) -> acc_out=-23, fire=0; acc_out=0 compared against THRESH=0 gives fire=1 (boundary).
REQ-031 start held high continuously -> one evaluation per 14 cycles (13 + IDLE); starts during busy/DONE ignored, done pulses exactly one cycle.
REQ-032 rst_n pulsed low at cycle 6 of an evaluation -> outputs zero at once, no done pulse; a subsequent start gives the correct result, 23.
REQ-033 All weights 16'h8000 and inputs 16'h8000, N_INPUTS=10 -> acc_out = 10 * 2^30, with no wrap at ACC_W=40.
REQ-034 N_INPUTS=1, weight 7, input -3 -> done 4 cycles after start, acc_out=-21, fire=0.
